// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU control of the program loader.
// master = stream source / system side, slave = the loader.
interface program_loader_if #(
    parameter int unsigned ADR_W  = 12,
    parameter int unsigned INST_W = 14
);
    logic              loadReq;
    logic              inValid;
    logic [7:0]        inData;
    logic              inReady;
    logic              imemWriteEn;
    logic [ADR_W-1:0]  imemAdr;
    logic [INST_W-1:0] imemData;
    logic              cpuRst;
    logic              done;
    logic              error;

    modport master (
        output loadReq, inValid, inData,
        input  inReady, imemWriteEn, imemAdr, imemData, cpuRst, done, error
    );

    modport slave (
        input  loadReq, inValid, inData,
        output inReady, imemWriteEn, imemAdr, imemData, cpuRst, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: count + byte-paired instructions -> instruction memory, then releases CPU reset.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
    parameter int unsigned ADR_W  = 12,
    parameter int unsigned INST_W = 14
) (
    input logic             clk,
    input logic             rst,
    program_loader_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StWLo,
        StWHi,
        StWrite,
        StRun,
        StErr
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        StChk
`endif
    } stateT;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam stateT DoneState = StChk;
`else
    localparam stateT DoneState = StRun;
`endif

    localparam int unsigned MaxCount = 32'd1 << ADR_W;
    // Bits of the high byte that lie above the instruction width must be zero.
    localparam logic [7:0]  HighMask = 8'hFF << (INST_W - 8);

    stateT             stateQ, stateD;
    logic [ADR_W:0]    adrQ, adrD;
    logic [15:0]       cntQ, cntD;
    logic [15:0]       countFull;
    logic [INST_W-1:0] wordQ, wordD;
    logic              pendQ, pendD;
    logic              xfer;
    logic              effReq;
    logic              inReadyInt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        xorQ, xorD;
`endif

    always_comb begin
        inReadyInt = 1'b0;
        case (stateQ)
            StCntLo, StCntHi, StWLo, StWHi: inReadyInt = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StChk:                          inReadyInt = 1'b1;
`endif
            default:                        inReadyInt = 1'b0;
        endcase
    end

    always_comb begin
        stateD    = stateQ;
        adrD      = adrQ;
        cntD      = cntQ;
        wordD     = wordQ;
        pendD     = 1'b0;
        countFull = {bus.inData, cntQ[7:0]};
        xfer      = bus.inValid && inReadyInt;
        effReq    = bus.loadReq || pendQ;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xorD = xorQ;
        if (xfer) begin
            xorD = xorQ ^ bus.inData;
        end
`endif

        if (stateQ == StWrite) begin
            // A restart requested during the write strobe is deferred by one cycle.
            pendD = bus.loadReq;
            adrD  = adrQ + (ADR_W + 1)'(1);
            cntD  = cntQ - 16'd1;
            stateD = (cntQ == 16'd1) ? DoneState : StWLo;
        end else if (effReq) begin
            stateD = StCntLo;
            adrD   = '0;
            cntD   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xorD = '0;
`endif
        end else if (xfer) begin
            case (stateQ)
                StCntLo: begin
                    cntD[7:0] = bus.inData;
                    stateD    = StCntHi;
                end
                StCntHi: begin
                    cntD = countFull;
                    if (countFull == 16'd0) begin
                        stateD = DoneState;
                    end else if ({16'd0, countFull} > MaxCount) begin
                        stateD = StErr;
                    end else begin
                        stateD = StWLo;
                    end
                end
                StWLo: begin
                    wordD[7:0] = bus.inData;
                    stateD     = StWHi;
                end
                StWHi: begin
                    if (|(bus.inData & HighMask)) begin
                        stateD = StErr;
                    end else begin
                        wordD[INST_W-1:8] = bus.inData[INST_W-9:0];
                        stateD            = StWrite;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                StChk: begin
                    stateD = (bus.inData == xorQ) ? StRun : StErr;
                end
`endif
                default: stateD = stateQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            adrQ   <= '0;
            cntQ   <= '0;
            wordQ  <= '0;
            pendQ  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xorQ   <= '0;
`endif
        end else begin
            stateQ <= stateD;
            adrQ   <= adrD;
            cntQ   <= cntD;
            wordQ  <= wordD;
            pendQ  <= pendD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xorQ   <= xorD;
`endif
        end
    end

    // The extra counter bit only ever sets after the final write; it also blocks any write past
    // the top of memory.
    assign bus.inReady     = inReadyInt;
    assign bus.imemWriteEn = (stateQ == StWrite) && !adrQ[ADR_W];
    assign bus.imemAdr     = adrQ[ADR_W-1:0];
    assign bus.imemData    = wordQ;
    assign bus.cpuRst      = (stateQ != StRun);
    assign bus.done        = (stateQ == StRun);
    assign bus.error       = (stateQ == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: vector table of whole loads plus multi-cycle corner cases.
module tb_program_loader;
    localparam int unsigned AdrW  = 12;
    localparam int unsigned InstW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    program_loader_if #(.ADR_W(AdrW), .INST_W(InstW)) bus();

    program_loader #(.ADR_W(AdrW), .INST_W(InstW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int cmpCount = 0;
    int errCount = 0;
    int wrAdr[$];
    int wrData[$];

    always @(negedge clk) begin
        if (bus.imemWriteEn === 1'b1) begin
            wrAdr.push_back(int'(bus.imemAdr));
            wrData.push_back(int'(bus.imemData));
        end
    end

    typedef struct packed {
        logic [63:0] bytes;    // first byte in [7:0]
        logic [3:0]  nBytes;
        logic [1:0]  nWrites;
        logic [15:0] adr0;
        logic [15:0] data0;
        logic [15:0] adr1;
        logic [15:0] data1;
        logic        expDone;
        logic        expError;
    } vecT;

    vecT vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        cmpCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseLoad();
        bus.loadReq = 1'b1;
        step();
        bus.loadReq = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit sent = 1'b0;
        bus.inValid = 1'b0;
        repeat (gap) step();
        bus.inValid = 1'b1;
        bus.inData  = b;
        for (int i = 0; i < 20 && !sent; i++) begin
            @(negedge clk);
            if (bus.inReady === 1'b1) sent = 1'b1;
            step();
        end
        bus.inValid = 1'b0;
        check("byteAccepted", 32'(sent), 32'd1);
    endtask

    task automatic clearWrites();
        wrAdr.delete();
        wrData.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bigWords[4096];
        logic [7:0] ck;
        int bad;

        bus.loadReq = 1'b0;
        bus.inValid = 1'b0;
        bus.inData  = 8'h00;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        vecs[0] = '{64'h00E4_3FFF_1234_0002, 4'd7, 2'd2, 16'h0, 16'h1234, 16'h1, 16'h3FFF, 1, 0};
        vecs[2] = '{64'h0000_0000_0000_0000, 4'd3, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0};
        vecs[4] = '{64'h0000_00AB_01AB_0001, 4'd5, 2'd1, 16'h0, 16'h01AB, 16'h0, 16'h0, 1, 0};
`else
        vecs[0] = '{64'h0000_3FFF_1234_0002, 4'd6, 2'd2, 16'h0, 16'h1234, 16'h1, 16'h3FFF, 1, 0};
        vecs[2] = '{64'h0000_0000_0000_0000, 4'd2, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0};
        vecs[4] = '{64'h0000_0000_01AB_0001, 4'd4, 2'd1, 16'h0, 16'h01AB, 16'h0, 16'h0, 1, 0};
`endif
        vecs[1] = '{64'h0000_0000_4000_0001, 4'd4, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1};
        vecs[3] = '{64'h0000_0000_0000_1001, 4'd2, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1};
        vecs[5] = '{64'h0000_0000_8055_0001, 4'd4, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1};
        vecs[6] = '{64'h0000_C222_1111_0002, 4'd6, 2'd1, 16'h0, 16'h1111, 16'h0, 16'h0, 0, 1};

        // Reset state
        repeat (3) step();
        check("rstCpuRst", 32'(bus.cpuRst), 32'd1);
        check("rstDone", 32'(bus.done), 32'd0);
        check("rstError", 32'(bus.error), 32'd0);
        check("rstInReady", 32'(bus.inReady), 32'd0);
        check("rstWriteEn", 32'(bus.imemWriteEn), 32'd0);
        check("rstAdr", 32'(bus.imemAdr), 32'd0);
        check("rstData", 32'(bus.imemData), 32'd0);
        rst = 1'b0;
        repeat (2) step();
        check("idleCpuRst", 32'(bus.cpuRst), 32'd1);

        // Table-driven whole loads
        foreach (vecs[v]) begin
            clearWrites();
            pulseLoad();
            check($sformatf("v%0d.readyAfterLoad", v), 32'(bus.inReady), 32'd1);
            for (int b = 0; b < int'(vecs[v].nBytes); b++) begin
                sendByte(vecs[v].bytes[8*b +: 8], 0);
            end
            repeat (3) step();
            check($sformatf("v%0d.writes", v), 32'(wrAdr.size()), 32'(vecs[v].nWrites));
            if (vecs[v].nWrites >= 1 && wrAdr.size() >= 1) begin
                check($sformatf("v%0d.adr0", v), 32'(wrAdr[0]), 32'(vecs[v].adr0));
                check($sformatf("v%0d.data0", v), 32'(wrData[0]), 32'(vecs[v].data0));
            end
            if (vecs[v].nWrites >= 2 && wrAdr.size() >= 2) begin
                check($sformatf("v%0d.adr1", v), 32'(wrAdr[1]), 32'(vecs[v].adr1));
                check($sformatf("v%0d.data1", v), 32'(wrData[1]), 32'(vecs[v].data1));
            end
            check($sformatf("v%0d.done", v), 32'(bus.done), 32'(vecs[v].expDone));
            check($sformatf("v%0d.error", v), 32'(bus.error), 32'(vecs[v].expError));
            check($sformatf("v%0d.cpuRst", v), 32'(bus.cpuRst), 32'(!vecs[v].expDone));
            check($sformatf("v%0d.inReady", v), 32'(bus.inReady), 32'd0);
        end

        // loadReq in RUN re-asserts cpuRst on the next cycle
        pulseLoad();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sendByte(8'h00, 0);
`endif
        step();
        check("runCpuRst", 32'(bus.cpuRst), 32'd0);
        pulseLoad();
        check("restartCpuRst", 32'(bus.cpuRst), 32'd1);
        check("restartDone", 32'(bus.done), 32'd0);

        // Write strobe in the cycle after the high byte, single cycle wide
        clearWrites();
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'hCD, 0);
        sendByte(8'h02, 0);
        check("latWriteEn", 32'(bus.imemWriteEn), 32'd1);
        check("latAdr", 32'(bus.imemAdr), 32'd0);
        check("latData", 32'(bus.imemData), 32'h02CD);
        step();
        check("latWriteEnDrop", 32'(bus.imemWriteEn), 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("latChkReady", 32'(bus.inReady), 32'd1);
`else
        check("latDone", 32'(bus.done), 32'd1);
        check("latCpuRst", 32'(bus.cpuRst), 32'd0);
`endif

        // Backpressure: random gaps leave the write sequence unchanged
        clearWrites();
        pulseLoad();
        for (int b = 0; b < int'(vecs[0].nBytes); b++) begin
            sendByte(vecs[0].bytes[8*b +: 8], int'($urandom_range(0, 3)));
        end
        repeat (3) step();
        check("bpWrites", 32'(wrAdr.size()), 32'd2);
        if (wrAdr.size() == 2) begin
            check("bpAdr1", 32'(wrAdr[1]), 32'd1);
            check("bpData0", 32'(wrData[0]), 32'h1234);
            check("bpData1", 32'(wrData[1]), 32'h3FFF);
        end
        check("bpDone", 32'(bus.done), 32'd1);

        // Restart while in W_HI: next write goes to address 0
        clearWrites();
        pulseLoad();
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        sendByte(8'h34, 0);
        sendByte(8'h12, 0);
        sendByte(8'hAA, 0);
        pulseLoad();
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'h56, 0);
        sendByte(8'h07, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sendByte(8'h50, 0);
`endif
        repeat (3) step();
        check("midWrites", 32'(wrAdr.size()), 32'd2);
        if (wrAdr.size() == 2) begin
            check("midAdr", 32'(wrAdr[1]), 32'd0);
            check("midData", 32'(wrData[1]), 32'h0756);
        end
        check("midDone", 32'(bus.done), 32'd1);

        // Full memory: 4096 words, last at 0xFFF
        clearWrites();
        pulseLoad();
        sendByte(8'h00, 0);
        sendByte(8'h10, 0);
        ck = 8'h10;
        for (int i = 0; i < 4096; i++) begin
            bigWords[i] = (i * 7 + 3) & 32'h3FFF;
            sendByte(8'(bigWords[i]), 0);
            sendByte(8'(bigWords[i] >> 8), 0);
            ck = ck ^ 8'(bigWords[i]) ^ 8'(bigWords[i] >> 8);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        step();
        sendByte(ck, 0);
`endif
        repeat (3) step();
        check("bigWrites", 32'(wrAdr.size()), 32'd4096);
        if (wrAdr.size() > 0) begin
            check("bigLastAdr", 32'(wrAdr[wrAdr.size()-1]), 32'hFFF);
        end
        bad = 0;
        for (int i = 0; i < wrAdr.size() && i < 4096; i++) begin
            if (wrAdr[i] != i || wrData[i] != bigWords[i]) bad++;
        end
        check("bigContents", 32'(bad), 32'd0);
        check("bigDone", 32'(bus.done), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum good and bad
        clearWrites();
        pulseLoad();
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'h34, 0);
        sendByte(8'h12, 0);
        sendByte(8'h27, 0);
        step();
        check("ckGoodDone", 32'(bus.done), 32'd1);
        clearWrites();
        pulseLoad();
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'h34, 0);
        sendByte(8'h12, 0);
        sendByte(8'h26, 0);
        step();
        check("ckBadError", 32'(bus.error), 32'd1);
        check("ckBadCpuRst", 32'(bus.cpuRst), 32'd1);
        check("ckBadWrites", 32'(wrAdr.size()), 32'd1);
        if (wrData.size() == 1) check("ckBadData", 32'(wrData[0]), 32'h1234);
`endif

        // Asynchronous reset mid-load
        pulseLoad();
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        sendByte(8'h34, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arstInReady", 32'(bus.inReady), 32'd0);
        check("arstCpuRst", 32'(bus.cpuRst), 32'd1);
        check("arstAdr", 32'(bus.imemAdr), 32'd0);
        step();
        rst = 1'b0;
        repeat (2) step();
        check("arstIdleReady", 32'(bus.inReady), 32'd0);
        check("arstIdleDone", 32'(bus.done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
